output_drain_buffer: RTL

Collects one full result frame from the compute array in a single parallel load and drains it to the output SRAM as row-major chunks of `OUTPUT_SRAM_LEN` values per beat, using a valid/ready handshake. It mirrors the input-side buffer, which is filled from SRAM in chunks and presented in parallel to the array. The block sits between the PE array result outputs and the output SRAM write port.

---
 rtl/output_drain_buffer.sv | 131 +++++++++++++
 1 files changed

// File: rtl/output_drain_buffer.sv
// output_drain_buffer: captures a full H x W result frame in one parallel load
// and drains it to the output SRAM as row-major beats of OUTPUT_SRAM_LEN values
// over a valid/ready handshake. One IDLE cycle separates consecutive frames.
module output_drain_buffer #(
  parameter int unsigned BIN_LEN         = 16,
  parameter int unsigned OUTPUT_HEIGHT   = 4,
  parameter int unsigned OUTPUT_WIDTH    = 8,
  parameter int unsigned OUTPUT_SRAM_LEN = 4
) (
  input  logic                                            clock,
  input  logic                                            reset_n,
  input  logic                                            load_valid,
  output logic                                            load_ready,
  input  logic [BIN_LEN*OUTPUT_HEIGHT*OUTPUT_WIDTH-1:0]   load_val,
  output logic                                            SRAM_valid,
  input  logic                                            SRAM_ready,
  output logic [BIN_LEN*OUTPUT_SRAM_LEN-1:0]              SRAM_out,
  output logic [$clog2(OUTPUT_HEIGHT)-1:0]                SRAM_r,
  output logic [$clog2(OUTPUT_WIDTH)-1:0]                 SRAM_c,
  output logic                                            SRAM_last,
  output logic                                            done
);

  localparam int unsigned RW = $clog2(OUTPUT_HEIGHT);
  localparam int unsigned CW = $clog2(OUTPUT_WIDTH);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t                state_q;
  logic [RW-1:0]         r_q, r_d;
  logic [CW-1:0]         c_q, c_d;
  logic                  done_q;
  logic [BIN_LEN-1:0]    frame_q [OUTPUT_HEIGHT][OUTPUT_WIDTH];

  logic                  draining;
  logic                  accept;
  logic                  row_end;
  logic                  frame_end;
  logic                  load_take;

  // Handshake decode and next row/column position after an accepted beat.
  always_comb begin
    draining  = (state_q == DRAIN);
    accept    = draining && SRAM_ready;
    load_take = (state_q == IDLE) && load_valid;
    // W is a multiple of LEN, so c+LEN < W is equivalent to c != W-LEN.
    row_end   = (c_q == CW'(OUTPUT_WIDTH - OUTPUT_SRAM_LEN));
    frame_end = row_end && (r_q == RW'(OUTPUT_HEIGHT - 1));
    r_d       = r_q;
    c_d       = c_q;
    if (accept) begin
      if (frame_end) begin
        r_d = '0;
        c_d = '0;
      end else if (row_end) begin
        r_d = r_q + RW'(1);
        c_d = '0;
      end else begin
        c_d = c_q + CW'(OUTPUT_SRAM_LEN);
      end
    end
  end

  // Control FSM: state, beat position and the one-cycle done pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      c_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load_valid) begin
            state_q <= DRAIN;
            r_q     <= '0;
            c_q     <= '0;
          end
        end
        DRAIN: begin
          r_q <= r_d;
          c_q <= c_d;
          if (accept && frame_end) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Frame register: parallel capture of the whole frame, only while idle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < OUTPUT_HEIGHT; i++) begin
        for (int unsigned j = 0; j < OUTPUT_WIDTH; j++) begin
          frame_q[i][j] <= '0;
        end
      end
    end else if (load_take) begin
      for (int unsigned i = 0; i < OUTPUT_HEIGHT; i++) begin
        for (int unsigned j = 0; j < OUTPUT_WIDTH; j++) begin
          frame_q[i][j] <= load_val[(i*OUTPUT_WIDTH+j)*BIN_LEN +: BIN_LEN];
        end
      end
    end
  end

  // Beat output mux; everything is forced to zero when no beat is presented.
  always_comb begin
    SRAM_out = '0;
    if (draining) begin
      for (int unsigned k = 0; k < OUTPUT_SRAM_LEN; k++) begin
        SRAM_out[k*BIN_LEN +: BIN_LEN] = frame_q[r_q][c_q + CW'(k)];
      end
    end
  end

  assign load_ready = (state_q == IDLE);
  assign SRAM_valid = draining;
  assign SRAM_r     = draining ? r_q : '0;
  assign SRAM_c     = draining ? c_q : '0;
  assign SRAM_last  = draining && frame_end;
  assign done       = done_q;

endmodule
